// File: rtl/turn_sched_pkg.sv
// Shared encodings for the turn scheduler: game modes, FSM states, player-count limits.
// Also holds the player-count clamp used when SETUP latches num_pl.
package turn_sched_pkg;

    localparam logic [2:0] MODE_SETUP  = 3'b010;
    localparam logic [2:0] MODE_PLAY   = 3'b011;

    localparam int PLAYERS_MAX = 4;
    localparam int PLAYERS_MIN = 2;

    typedef enum logic [2:0] {
        IDLE,
        READY,
        STEP,
        GAP,
        ROTATE
    } state_t;

    function automatic logic [2:0] clamp_players(input logic [2:0] n);
        if (n < 3'(PLAYERS_MIN)) return 3'(PLAYERS_MIN);
        if (n > 3'(PLAYERS_MAX)) return 3'(PLAYERS_MAX);
        return n;
    endfunction

endpackage

// File: rtl/step_pacer.sv
// Remaining-step and inter-strobe gap counters; registers the advance strobe.
// adv follows fire by one cycle; last/gap_end tell the FSM when to leave STEP/GAP.
module step_pacer #(
    parameter int STEP_GAP = 4,
    parameter int STEP_MAX = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [2:0] load_cnt,
    input  logic       clr,
    input  logic       fire,
    input  logic       in_step,
    input  logic       in_gap,
    output logic       adv,
    output logic       last,
    output logic       gap_end
);

    localparam int RW = $clog2(STEP_MAX + 1);
    localparam int GW = $clog2(STEP_GAP + 1);

    logic [RW-1:0] rem_q, rem_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          adv_q, adv_d;

    always_comb begin
        rem_d = rem_q;
        gap_d = gap_q;
        adv_d = fire;
        if (clr) begin
            rem_d = '0;
            gap_d = '0;
        end else if (load) begin
            rem_d = RW'(load_cnt);
        end else if (in_step) begin
            rem_d = rem_q - 1'b1;
            gap_d = GW'(STEP_GAP);
        end else if (in_gap) begin
            gap_d = gap_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            gap_q <= '0;
            adv_q <= 1'b0;
        end else begin
            rem_q <= rem_d;
            gap_q <= gap_d;
            adv_q <= adv_d;
        end
    end

    assign adv     = adv_q;
    assign last    = (rem_q == RW'(1));
    assign gap_end = (gap_q == GW'(1));

endmodule

// File: rtl/turn_sched.sv
// Turn scheduler: owns the current player and turns a K-step move into K spaced advance strobes.
// Optional lap detection / winner parking is built when TURN_SCHED_LAP_EN is defined.
module turn_sched
    import turn_sched_pkg::*;
#(
    parameter int STEP_GAP  = 4,
    parameter int STEP_MAX  = 7,
    parameter int BOARD_LEN = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] mode,
    input  logic [2:0] num_pl,
    input  logic       move_req,
    input  logic [2:0] move_steps,
    input  logic       miss,
    output logic [3:0] p_da,
    output logic       adv,
    output logic [1:0] turn,
    output logic       busy,
    output logic       move_done
`ifdef TURN_SCHED_LAP_EN
    ,
    output logic       lap_done,
    output logic [1:0] winner
`endif
);

    if (STEP_GAP < 1 || STEP_MAX < 1 || STEP_MAX > 7 || BOARD_LEN < 2 || BOARD_LEN > 32) begin : g_param_check
        $error("turn_sched: parameter out of range");
    end

    state_t     state_q, state_d;
    logic [1:0] turn_q, turn_d;
    logic [2:0] n_q, n_d;
    logic [3:0] p_da_q, p_da_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       load, clr, fire, last, gap_end;
    logic [2:0] load_cnt;
    logic       lap_cut, parked;

    always_comb begin
        state_d  = state_q;
        turn_d   = turn_q;
        n_d      = n_q;
        load     = 1'b0;
        load_cnt = (move_steps > 3'(STEP_MAX)) ? 3'(STEP_MAX) : move_steps;
        if (mode != MODE_PLAY) begin
            state_d = IDLE;
            if (mode == MODE_SETUP) begin
                n_d    = clamp_players(num_pl);
                turn_d = 2'd0;
            end
        end else begin
            case (state_q)
                IDLE:   if (!parked) state_d = READY;
                READY: begin
                    if (move_req && move_steps != 3'd0) begin
                        load    = 1'b1;
                        state_d = STEP;
                    end else if (move_req || miss) begin
                        state_d = ROTATE;
                    end
                end
                STEP:   state_d = (last || lap_cut) ? ROTATE : GAP;
                GAP:    if (gap_end) state_d = STEP;
                ROTATE: begin
                    turn_d  = ({1'b0, turn_q} + 3'd1 == n_q) ? 2'd0 : turn_q + 2'd1;
                    state_d = parked ? IDLE : READY;
                end
                default: state_d = IDLE;
            endcase
        end
        fire   = (state_d == STEP);
        clr    = !(state_d == STEP || state_d == GAP);
        busy_d = (state_d == STEP || state_d == GAP || state_d == ROTATE);
        done_d = (state_d == ROTATE);
        // select follows the committed turn, so it only moves after ROTATE
        p_da_d = 4'b0001 << turn_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            turn_q  <= 2'd0;
            n_q     <= 3'd2;
            p_da_q  <= 4'b0001;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            turn_q  <= turn_d;
            n_q     <= n_d;
            p_da_q  <= p_da_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    step_pacer #(
        .STEP_GAP (STEP_GAP),
        .STEP_MAX (STEP_MAX)
    ) u_pacer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_cnt (load_cnt),
        .clr      (clr),
        .fire     (fire),
        .in_step  (state_q == STEP),
        .in_gap   (state_q == GAP),
        .adv      (adv),
        .last     (last),
        .gap_end  (gap_end)
    );

`ifdef TURN_SCHED_LAP_EN
    logic [4:0] pos_q [PLAYERS_MAX];
    logic [4:0] pos_d [PLAYERS_MAX];
    logic       lap_q, lap_d, won_q, won_d;
    logic [1:0] win_q, win_d;

    always_comb begin
        pos_d = pos_q;
        lap_d = 1'b0;
        won_d = won_q | lap_q;
        win_d = win_q;
        if (mode == MODE_SETUP) begin
            for (int i = 0; i < PLAYERS_MAX; i++) pos_d[i] = '0;
            won_d = 1'b0;
            win_d = 2'd0;
        end else begin
            if (state_q == STEP)
                pos_d[turn_q] = (pos_q[turn_q] == 5'(BOARD_LEN - 1)) ? 5'd0 : pos_q[turn_q] + 5'd1;
            // flag the strobe that will carry the shadow from the last tile back to 0
            if (fire && pos_d[turn_q] == 5'(BOARD_LEN - 1)) begin
                lap_d = 1'b1;
                win_d = turn_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PLAYERS_MAX; i++) pos_q[i] <= '0;
            lap_q <= 1'b0;
            won_q <= 1'b0;
            win_q <= 2'd0;
        end else begin
            pos_q <= pos_d;
            lap_q <= lap_d;
            won_q <= won_d;
            win_q <= win_d;
        end
    end

    assign lap_cut  = lap_q;
    assign parked   = won_q;
    assign lap_done = lap_q;
    assign winner   = win_q;
`else
    assign lap_cut = 1'b0;
    assign parked  = 1'b0;
`endif

    assign p_da      = p_da_q;
    assign turn      = turn_q;
    assign busy      = busy_q;
    assign move_done = done_q;

endmodule

// File: tb/tb_turn_sched.sv
// Randomized bench for turn_sched against a timing/turn model derived from strobe arithmetic.
module tb_turn_sched;

    localparam int G    = 4;
    localparam int SMAX = 7;
    localparam int BL   = 24;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] mode, num_pl, move_steps;
    logic       move_req, miss;
    logic [3:0] p_da;
    logic       adv, busy, move_done;
    logic [1:0] turn;
`ifdef TURN_SCHED_LAP_EN
    logic       lap_done;
    logic [1:0] winner;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int m_n, m_turn;
    int m_pos [4];
    bit m_won;

    turn_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .num_pl     (num_pl),
        .move_req   (move_req),
        .move_steps (move_steps),
        .miss       (miss),
        .p_da       (p_da),
        .adv        (adv),
        .turn       (turn),
        .busy       (busy),
        .move_done  (move_done)
`ifdef TURN_SCHED_LAP_EN
        ,
        .lap_done   (lap_done),
        .winner     (winner)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_model;
        m_n    = 2;
        m_turn = 0;
        m_won  = 0;
        for (int i = 0; i < 4; i++) m_pos[i] = 0;
    endtask

    task automatic do_setup(input int n);
        mode   = 3'b010;
        num_pl = 3'(n);
        tick;
        tick;
        mode = 3'b011;
        tick;
        tick;
        reset_model();
        m_n = (n < 2) ? 2 : ((n > 4) ? 4 : n);
        chk("setup_turn", 32'(turn), 32'(0));
        chk("setup_pda", 32'(p_da), 32'(1));
    endtask

    // req/ms drive the request lines; noise throws extra requests while busy
    task automatic do_move(input bit req, input bit ms, input int steps, input bit noise);
        int  k, kk, done_r, nt, old;
        bit  lap, exp_adv;
        k   = (!req || steps == 0) ? 0 : ((steps > SMAX) ? SMAX : steps);
        kk  = k;
        lap = 0;
`ifdef TURN_SCHED_LAP_EN
        if (k > 0 && m_pos[m_turn] + k >= BL) begin
            lap = 1;
            kk  = BL - m_pos[m_turn];
        end
`endif
        done_r = (kk == 0) ? 1 : 2 + (kk - 1) * (G + 1);
        nt     = (m_turn + 1) % m_n;
        old    = m_turn;
        chk("pre_busy", 32'(busy), 32'(0));
        chk("pre_turn", 32'(turn), 32'(m_turn));
        chk("pre_pda", 32'(p_da), 32'(1 << m_turn));
        move_req   = req;
        miss       = ms;
        move_steps = 3'(steps);
        for (int r = 1; r <= done_r + 1; r++) begin
            tick;
            move_req = 1'b0;
            miss     = 1'b0;
            exp_adv  = (kk > 0) && (r < done_r) && ((r - 1) % (G + 1) == 0);
            chk("adv", 32'(adv), 32'(exp_adv));
            chk("move_done", 32'(move_done), 32'(r == done_r));
            chk("busy", 32'(busy), 32'(r <= done_r));
            chk("p_da", 32'(p_da), 32'((r <= done_r) ? (1 << old) : (1 << nt)));
`ifdef TURN_SCHED_LAP_EN
            chk("lap_done", 32'(lap_done), 32'(lap && r == done_r - 1));
`endif
            if (noise && r <= done_r && $urandom_range(0, 3) == 0) begin
                move_req   = 1'b1;
                miss       = 1'($urandom_range(0, 1));
                move_steps = 3'($urandom_range(0, 7));
            end
        end
        chk("post_turn", 32'(turn), 32'(nt));
        m_pos[old] = (m_pos[old] + kk) % BL;
        m_turn     = nt;
`ifdef TURN_SCHED_LAP_EN
        if (lap) begin
            m_won = 1;
            chk("winner", 32'(winner), 32'(old));
        end
`endif
    endtask

    initial begin
        int sel, st;
        int pl_list [5];
        pl_list = '{1, 6, 4, 2, 5};
        rst_n = 1'b0;
        mode = 3'b000; num_pl = 3'd0; move_req = 1'b0; miss = 1'b0; move_steps = 3'd0;
        #12;
        chk("rst_turn", 32'(turn), 32'(0));
        chk("rst_pda", 32'(p_da), 32'(1));
        chk("rst_adv", 32'(adv), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(move_done), 32'(0));
        rst_n = 1'b1;
        reset_model();

        // requests in HOLD do nothing
        move_req = 1'b1; move_steps = 3'd3;
        tick;
        move_req = 1'b0;
        tick;
        chk("hold_busy", 32'(busy), 32'(0));
        chk("hold_adv", 32'(adv), 32'(0));

        // directed: 3 players, 3 steps, then misses around the table
        do_setup(3);
        do_move(1, 0, 3, 0);
        do_move(0, 1, 0, 0);
        do_move(0, 1, 0, 0);
        do_move(0, 1, 0, 0);
        do_move(1, 1, 2, 0);

        for (int s = 0; s < 5; s++) begin
            do_setup(pl_list[s]);
            for (int m = 0; m < 9; m++) begin
                if (m_won) break;
                sel = $urandom_range(0, 9);
                st  = $urandom_range(1, 7);
                if (sel < 3)       do_move(0, 1, 0, 1'($urandom_range(0, 1)));
                else if (sel == 3) do_move(1, 0, 0, 1'($urandom_range(0, 1)));
                else if (sel == 4) do_move(1, 1, st, 1'($urandom_range(0, 1)));
                else               do_move(1, 0, st, 1'($urandom_range(0, 1)));
            end
        end

        // abort to HOLD after the 2nd of 5 strobes
        do_setup(2);
        move_req = 1'b1; move_steps = 3'd5;
        for (int r = 1; r <= 6; r++) begin
            tick;
            move_req = 1'b0;
            chk("ab_adv", 32'(adv), 32'(r == 1 || r == 6));
        end
        mode = 3'b000;
        for (int r = 0; r < 15; r++) begin
            tick;
            chk("ab_adv_off", 32'(adv), 32'(0));
            chk("ab_done_off", 32'(move_done), 32'(0));
            chk("ab_busy_off", 32'(busy), 32'(0));
        end
        chk("ab_turn", 32'(turn), 32'(m_turn));
        m_pos[m_turn] = m_pos[m_turn] + 2;
        mode = 3'b011;
        tick;
        do_move(1, 0, 2, 0);

        // asynchronous reset in the middle of a gap
        do_setup(4);
        do_move(0, 1, 0, 0);
        move_req = 1'b1; move_steps = 3'd3;
        tick; move_req = 1'b0;
        tick;
        tick;
        rst_n = 1'b0;
        #1;
        chk("ar_turn", 32'(turn), 32'(0));
        chk("ar_pda", 32'(p_da), 32'(1));
        chk("ar_adv", 32'(adv), 32'(0));
        chk("ar_busy", 32'(busy), 32'(0));
        chk("ar_done", 32'(move_done), 32'(0));
        tick;
        rst_n = 1'b1;
        reset_model();
        tick;
        tick;
        do_move(0, 1, 0, 0);
        do_move(0, 1, 0, 0);

`ifdef TURN_SCHED_LAP_EN
        // player 0 walks to tile 22, then a 4-step move laps after 2 strobes
        do_setup(2);
        do_move(1, 0, 7, 0); do_move(0, 1, 0, 0);
        do_move(1, 0, 7, 0); do_move(0, 1, 0, 0);
        do_move(1, 0, 7, 0); do_move(0, 1, 0, 0);
        do_move(1, 0, 1, 0); do_move(0, 1, 0, 0);
        chk("lap_pos", 32'(m_pos[0]), 32'(22));
        do_move(1, 0, 4, 0);
        move_req = 1'b1; move_steps = 3'd2;
        tick; move_req = 1'b0;
        tick;
        chk("parked_busy", 32'(busy), 32'(0));
        chk("parked_winner", 32'(winner), 32'(0));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/turn_sched.md
Name: turn_sched

Overview:
- Turn scheduler and step sequencer for the shared player-position counters (one 0..23 wrap counter per player, driven by a common advance strobe plus a per-player select).
- Owns whose turn it is among 2..4 players.
- Converts a move request of K steps into K spaced single-cycle advance strobes aimed at the current player, then rotates the turn.
- Sits between the game-mode FSM / card-match logic and the per-player counters.

Parameters:
- STEP_GAP, 4: idle cycles between consecutive advance strobes (min 1).
- STEP_MAX, 7: largest legal step count per move.
- BOARD_LEN, 24: tiles per lap; counters wrap BOARD_LEN-1 -> 0.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  3  game mode; 3'b010 = SETUP, 3'b011 = PLAY, others = HOLD.
- num_pl  in  3  player count, legal 2..4, sampled on SETUP.
- move_req  in  1  one-cycle request: current player moves move_steps tiles.
- move_steps  in  3  step count for move_req, 1..STEP_MAX.
- miss  in  1  one-cycle request: current player forfeits turn (0 steps).
- p_da  out  4  one-hot select of the player whose counter advances.
- adv  out  1  advance strobe to the counters (D).
- turn  out  2  index of the current player.
- busy  out  1  high while a move or pass is in progress.
- move_done  out  1  one-cycle pulse when the move/pass completes and the turn has rotated.

Behaviour:
- Reset (async, rst_n=0): state IDLE, turn=0, p_da=4'b0001, adv=0, busy=0, move_done=0, step counter 0, n_reg=2.
- IDLE: entered on reset and whenever mode is not PLAY.
  - mode==SETUP: latch n_reg = num_pl clamped to 2..4 (0,1 -> 2; 5..7 -> 4); turn=0.
  - mode==PLAY -> READY.
- READY: p_da = onehot(turn), adv=0.
  - move_req with move_steps in 1..STEP_MAX: latch remaining=move_steps, go STEP.
  - move_steps==0 is treated as miss; move_steps>STEP_MAX is clamped to STEP_MAX.
  - miss: go ROTATE.
  - move_req and miss in the same cycle: move_req wins.
- STEP: adv=1 for exactly one cycle, remaining decrements.
  - remaining becomes 0 -> ROTATE.
  - otherwise -> GAP with gap count = STEP_GAP.
- GAP: adv=0; count down.
  - Reaches 0 -> STEP.
  - K steps produce K strobes with period STEP_GAP+1; first strobe one cycle after the request.
- ROTATE: one cycle; turn = (turn+1 == n_reg) ? 0 : turn+1.
  - move_done=1 in this cycle; p_da updates the cycle after.
  - Then -> READY.
- busy=1 in STEP, GAP and ROTATE.
- move_req/miss while busy are ignored (no queueing).
- p_da stays stable on the moving player from the request until ROTATE completes, so counters never see a select change alongside adv.
- Leaving PLAY mid-move (mode changes): abort to IDLE next cycle, adv=0, remaining cleared, no move_done, turn preserved unless SETUP.
- Reset asserted mid-move: immediate return to reset values.
- Counter wrap (23 -> 0) is the counters' job; the scheduler never issues more than STEP_MAX strobes per move.

Optional Feature:
- Macro: TURN_SCHED_LAP_EN.
- Defined:
  - Adds 4 shadow positions, 5 bits each, mod BOARD_LEN. Each is cleared in SETUP and incremented on each adv for the selected player.
  - Adds outputs lap_done (1-cycle pulse on the strobe where the shadow wraps BOARD_LEN-1 -> 0) and winner[1:0] (index of that player, held until the next SETUP).
  - After lap_done, the remaining strobes of that move are cancelled: ROTATE follows, and the FSM parks in IDLE until SETUP.
- Undefined: no shadow registers, ports absent, play continues indefinitely.

Decomposition:
- Package turn_sched_pkg holds:
  - mode encodings MODE_SETUP=3'b010 and MODE_PLAY=3'b011;
  - the state enum (IDLE, READY, STEP, GAP, ROTATE);
  - PLAYERS_MAX=4 and the clamp limits.
- One natural sub-module: step_pacer. It holds the remaining/gap counters, takes load+count and emits the adv strobes plus a last flag. The FSM and turn rotation stay in the top level.

Test Plan:
- Reset-release, then SETUP num_pl=3, then PLAY, then move_req steps=3, STEP_GAP=4: adv high at cycles +1, +6, +11 with p_da=0001; move_done at +12; turn=1, p_da=0010 at +13.
- 3-player rotation with miss on each turn: no adv; turn sequence 0,1,2,0; one move_done per miss.
- num_pl=1 and num_pl=6 in SETUP: rotation wraps at 2 and 4 players respectively.
- move_req during GAP and move_req+miss in the same cycle: the extra request is ignored; the simultaneous pair performs the move.
- mode switched to HOLD after the 2nd of 5 strobes: no further adv, no move_done, turn unchanged. rst_n pulsed mid-GAP: outputs return to reset values asynchronously.
- With TURN_SCHED_LAP_EN: player 0 at shadow position 22 moves 4 steps. The 2nd strobe wraps, giving lap_done with winner=0, and exactly 2 adv strobes are issued.
